// File: rtl/pb_slot_queue.sv
// pb_slot_queue: ring of fixed-size packet slots in the packet buffer RAM.
// The write side packs the incoming byte stream into slot {tail, wr_cnt} and
// commits a slot after SLOT_LEN bytes. The read side hands slot base addresses
// to the transmit path and retires the slot when the transmit path reports done.
// Optional feature macro: PB_SLOT_QUEUE_STATS_EN adds the drop_cnt output, a
// saturating 16-bit counter of slots dropped because the ring was full.
module pb_slot_queue #(
    parameter int SLOT_LEN    = 1024,
    parameter int QUEUE_LEN   = 4,
    localparam int RAM_SIZE   = SLOT_LEN * QUEUE_LEN,
    localparam int RAM_AW     = $clog2(RAM_SIZE),
    localparam int CNT_W      = $clog2(QUEUE_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_abort,
    input  logic              inclk,
    input  logic [7:0]        in,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [7:0]        ram_win,
    output logic              tx_start,
    output logic [RAM_AW-1:0] tx_read_start,
    input  logic              tx_done,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
`ifdef PB_SLOT_QUEUE_STATS_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int SLOT_W = $clog2(SLOT_LEN);
    localparam int PTR_W  = CNT_W;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [SLOT_W-1:0] wr_cnt_q, wr_cnt_d;
    state_t            state_q, state_d;
    logic              tx_start_q, tx_start_d;

    logic [PTR_W-1:0]  tail_inc;
    logic              accept;
    logic              last_byte;

    // Status flags derived from the registered pointers only.
    always_comb begin
        tail_inc  = tail_q + PTR_ONE;
        empty     = (head_q == tail_q);
        full      = (tail_inc == head_q);
        count     = tail_q - head_q;
        accept    = inclk && !in_abort;
        last_byte = (wr_cnt_q == SLOT_LAST);
    end

    // Write port goes straight to the RAM so each byte lands in the same cycle.
    always_comb begin
        ram_we    = accept;
        ram_win   = in;
        ram_waddr = {tail_q, wr_cnt_q};
    end

    // Byte packing: abort discards the partial slot; a full ring drops the slot.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        tail_d   = tail_q;
        if (in_abort) begin
            wr_cnt_d = '0;
        end else if (inclk) begin
            if (last_byte) begin
                wr_cnt_d = '0;
                if (!full) begin
                    tail_d = tail_inc;
                end
            end else begin
                wr_cnt_d = wr_cnt_q + SLOT_ONE;
            end
        end
    end

    // Read FSM next-state: announce the head slot, then wait for it to finish.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        head_d     = head_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d    = S_START;
                    tx_start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (tx_done) begin
                    head_d  = head_q + PTR_ONE;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Head only moves on retire, so the slot base address holds for the whole transfer.
    always_comb begin
        tx_start      = tx_start_q;
        tx_read_start = {head_q, {SLOT_W{1'b0}}};
    end

    // State registers for both the write side and the read FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            wr_cnt_q   <= '0;
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            wr_cnt_q   <= wr_cnt_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
        end
    end

`ifdef PB_SLOT_QUEUE_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop;

    // A completed slot with no free ring entry is a drop; the counter saturates.
    always_comb begin
        drop       = accept && last_byte && full;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pb_slot_queue.sv
// Directed bench for pb_slot_queue with the default geometry (1024-byte slots,
// 4 slots). Models the packet RAM to check the data that the transmit side reads.
module tb_pb_slot_queue;

    localparam int SLOT = 1024;

    logic        clk;
    logic        rst;
    logic        in_abort;
    logic        inclk;
    logic [7:0]  din;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [7:0]  ram_win;
    logic        tx_start;
    logic [11:0] tx_read_start;
    logic        tx_done;
    logic [1:0]  count;
    logic        empty;
    logic        full;
`ifdef PB_SLOT_QUEUE_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:4095];

    pb_slot_queue dut (
        .clk           (clk),
        .rst           (rst),
        .in_abort      (in_abort),
        .inclk         (inclk),
        .in            (din),
        .ram_we        (ram_we),
        .ram_waddr     (ram_waddr),
        .ram_win       (ram_win),
        .tx_start      (tx_start),
        .tx_read_start (tx_read_start),
        .tx_done       (tx_done),
        .count         (count),
        .empty         (empty),
        .full          (full)
`ifdef PB_SLOT_QUEUE_STATS_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_win;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        inclk;
        logic        abort;
        logic [7:0]  din;
        logic        exp_we;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int exp_addr);
        inclk = 1'b1;
        din   = 8'(d);
        #1;
        chk("wr_addr", 32'(ram_waddr), exp_addr);
        tick();
        inclk = 1'b0;
    endtask

    task automatic write_bytes(input int seed, input int tail, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            send((seed + i) & 255, tail * SLOT + i);
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    function automatic int slot_errors(input int base, input int seed);
        int bad = 0;
        for (int i = 0; i < SLOT; i++) begin
            if (mem[base + i] !== 8'((seed + i) & 255)) bad++;
        end
        return bad;
    endfunction

    initial begin
        rst      = 1'b1;
        in_abort = 1'b0;
        inclk    = 1'b0;
        din      = 8'h00;
        tx_done  = 1'b0;

        vt[0] = '{1'b1, 1'b0, 8'hAA, 1'b1, 12'd0};
        vt[1] = '{1'b0, 1'b0, 8'h55, 1'b0, 12'd1};
        vt[2] = '{1'b1, 1'b0, 8'h11, 1'b1, 12'd1};
        vt[3] = '{1'b1, 1'b1, 8'h22, 1'b0, 12'd2};
        vt[4] = '{1'b1, 1'b0, 8'h33, 1'b1, 12'd0};
        vt[5] = '{1'b0, 1'b1, 8'h44, 1'b0, 12'd1};
        vt[6] = '{1'b1, 1'b0, 8'h66, 1'b1, 12'd0};
        vt[7] = '{1'b1, 1'b1, 8'h77, 1'b0, 12'd1};
        vt[8] = '{1'b0, 1'b0, 8'h88, 1'b0, 12'd0};

        // reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_read_start", 32'(tx_read_start), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
`ifdef PB_SLOT_QUEUE_STATS_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
`endif

        // write-path vectors including abort priority
        for (int v = 0; v < 9; v++) begin
            inclk    = vt[v].inclk;
            in_abort = vt[v].abort;
            din      = vt[v].din;
            #1;
            chk("vec_we", 32'(ram_we), 32'(vt[v].exp_we));
            chk("vec_waddr", 32'(ram_waddr), 32'(vt[v].exp_addr));
            chk("vec_win", 32'(ram_win), 32'(vt[v].din));
            tick();
        end
        inclk    = 1'b0;
        in_abort = 1'b0;
        #1;
        chk("vec_count", 32'(count), 0);

        // one full slot, then transmit and retire it
        write_bytes(0, 0, 0, SLOT);
        chk("t1_count", 32'(count), 1);
        chk("t1_empty", 32'(empty), 0);
        chk("t1_start_early", 32'(tx_start), 0);
        tick();
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_read_start", 32'(tx_read_start), 0);
        tick();
        chk("t1_start_one_cycle", 32'(tx_start), 0);
        chk("t1_data", 32'(slot_errors(0, 0)), 0);
        pulse_done();
        chk("t1_done_count", 32'(count), 0);
        chk("t1_done_empty", 32'(empty), 1);
        chk("t1_head_adv", 32'(tx_read_start), 1024);

        // fill to capacity, then drop a slot
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) write_bytes(16 * s, s, 0, SLOT);
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 3);
        write_bytes(8'h80, 3, 0, SLOT);
        chk("drop_full", 32'(full), 1);
        chk("drop_count", 32'(count), 3);
        chk("drop_tail", 32'(ram_waddr), 3072);
`ifdef PB_SLOT_QUEUE_STATS_EN
        chk("drop_cnt", 32'(drop_cnt), 1);
`endif
        pulse_done();
        chk("unfull_flag", 32'(full), 0);
        chk("unfull_count", 32'(count), 2);
        chk("unfull_head", 32'(tx_read_start), 1024);

        // partial slot abandoned by in_abort
        write_bytes(8'h90, 3, 0, 500);
        in_abort = 1'b1;
        inclk    = 1'b1;
        din      = 8'hEE;
        #1;
        chk("abort_no_we", 32'(ram_we), 0);
        tick();
        in_abort = 1'b0;
        inclk    = 1'b0;
        #1;
        chk("abort_wr_cnt", 32'(ram_waddr), 3072);
        chk("abort_count", 32'(count), 2);

        // commit and retire on the same edge
        write_bytes(8'hA0, 3, 0, SLOT - 1);
        inclk   = 1'b1;
        din     = 8'(8'hA0 + 8'd255);
        tx_done = 1'b1;
        #1;
        chk("cr_last_addr", 32'(ram_waddr), 4095);
        tick();
        inclk   = 1'b0;
        tx_done = 1'b0;
        chk("cr_count", 32'(count), 2);
        chk("cr_head", 32'(tx_read_start), 2048);
        chk("cr_tail_wrap", 32'(ram_waddr), 0);

        // done outside ACTIVE is ignored (IDLE then START)
        pulse_done();
        chk("done_idle_count", 32'(count), 2);
        chk("done_idle_start", 32'(tx_start), 1);
        pulse_done();
        chk("done_start_count", 32'(count), 2);
        chk("done_start_head", 32'(tx_read_start), 2048);

        // reset while a slot is in flight
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_tx_start", 32'(tx_start), 0);
        chk("mid_rst_ram_we", 32'(ram_we), 0);
        chk("mid_rst_head", 32'(tx_read_start), 0);
        chk("mid_rst_tail", 32'(ram_waddr), 0);
`ifdef PB_SLOT_QUEUE_STATS_EN
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);
`endif
        rst = 1'b0;
        tick();
        chk("post_rst_no_start", 32'(tx_start), 0);

        // nine slots through the ring with wrap-around
        for (int s = 0; s < 9; s++) begin
            bit seen;
            write_bytes(s * 37, s % 4, 0, SLOT);
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                if (tx_start) seen = 1'b1;
                else tick();
            end
            chk("fd_start_seen", 32'(seen), 1);
            chk("fd_read_start", 32'(tx_read_start), (s % 4) * SLOT);
            chk("fd_data", 32'(slot_errors((s % 4) * SLOT, s * 37)), 0);
            tick();
            pulse_done();
            chk("fd_empty", 32'(empty), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
